// File: rtl/cpu_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_decoder
// Description : Decodes NES CPU-space transactions arriving from the bus
//               arbiter and dispatches them to internal RAM, PPU registers,
//               APU/IO registers or cartridge PRG. It returns read data with
//               a one-cycle I_Finish pulse and models open-bus reads.
//               Optional build macro PRG_RAM_EN adds an 8 KB work RAM at
//               0x6000-0x7FFF. That RAM uses the same timing as internal RAM.
// Ports       : clk/rst                 - clock, synchronous active-high reset
//               I_Addr/I_WData/I_RW/I_Cmd - upstream request (Cmd is a pulse)
//               I_RData/I_Finish        - upstream response
//               ram_*                   - internal 2 KB RAM (1-cycle read)
//               ppu_*                   - PPU register handshake
//               io_*                    - APU/IO register handshake
//               prg_*                   - cartridge PRG (1-cycle read)
//               wram_*                  - work RAM (PRG_RAM_EN only)
//               err_timeout             - sticky handshake timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_decoder #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] I_Addr,
    input  logic [7:0]  I_WData,
    input  logic        I_RW,
    input  logic        I_Cmd,
    output logic [7:0]  I_RData,
    output logic        I_Finish,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_en,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_rw,
    output logic        ppu_cmd,
    input  logic [7:0]  ppu_rdata,
    input  logic        ppu_finish,
    output logic [4:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_rw,
    output logic        io_cmd,
    input  logic [7:0]  io_rdata,
    input  logic        io_finish,
    output logic [14:0] prg_addr,
    output logic [7:0]  prg_wdata,
    output logic        prg_en,
    output logic        prg_we,
    input  logic [7:0]  prg_rdata,
    output logic        err_timeout
`ifdef PRG_RAM_EN
    ,
    output logic [12:0] wram_addr,
    output logic [7:0]  wram_wdata,
    output logic        wram_en,
    output logic        wram_we,
    input  logic [7:0]  wram_rdata
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEM     = 3'd1,
        S_MEMDATA = 3'd2,
        S_HS      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [2:0] c_RGN_RAM  = 3'd0;
    localparam logic [2:0] c_RGN_PPU  = 3'd1;
    localparam logic [2:0] c_RGN_IO   = 3'd2;
    localparam logic [2:0] c_RGN_PRG  = 3'd3;
    localparam logic [2:0] c_RGN_NONE = 3'd5;
`ifdef PRG_RAM_EN
    localparam logic [2:0] c_RGN_WRAM = 3'd4;
`endif
    localparam logic [TO_W-1:0] c_TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic [2:0]        region_q, region_d;
    logic              rw_q, rw_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        data_q, data_d;          // captured read data
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        open_bus_q, open_bus_d;
    logic              finish_q, finish_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [10:0]       ram_addr_q, ram_addr_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [2:0]        ppu_addr_q, ppu_addr_d;
    logic              ppu_cmd_q, ppu_cmd_d;
    logic [4:0]        io_addr_q, io_addr_d;
    logic              io_cmd_q, io_cmd_d;
    logic [14:0]       prg_addr_q, prg_addr_d;
    logic              prg_en_q, prg_en_d, prg_we_q, prg_we_d;
`ifdef PRG_RAM_EN
    logic [12:0]       wram_addr_q, wram_addr_d;
    logic              wram_en_q, wram_en_d, wram_we_q, wram_we_d;
`endif

    logic [2:0]        w_region;
    logic [7:0]        w_mem_rdata;
    logic              w_hs_finish;
    logic [7:0]        w_hs_rdata;
    logic [TO_W-1:0]   w_cnt_inc;

    // Region decode of the incoming address; the result is latched with I_Cmd.
    always_comb begin
        w_region = c_RGN_NONE;
        if (I_Addr[15:13] == 3'b000) begin
            w_region = c_RGN_RAM;
        end else if (I_Addr[15:13] == 3'b001) begin
            w_region = c_RGN_PPU;
        end else if (I_Addr[15:5] == 11'h200) begin
            w_region = c_RGN_IO;
        end else if (I_Addr[15]) begin
            w_region = c_RGN_PRG;
`ifdef PRG_RAM_EN
        end else if (I_Addr[15:13] == 3'b011) begin
            w_region = c_RGN_WRAM;
`endif
        end
    end

    always_comb begin
        w_mem_rdata = ram_rdata;
        if (region_q == c_RGN_PRG) begin
            w_mem_rdata = prg_rdata;
`ifdef PRG_RAM_EN
        end else if (region_q == c_RGN_WRAM) begin
            w_mem_rdata = wram_rdata;
`endif
        end
    end

    assign w_hs_finish = (region_q == c_RGN_PPU) ? ppu_finish : io_finish;
    assign w_hs_rdata  = (region_q == c_RGN_PPU) ? ppu_rdata  : io_rdata;
    assign w_cnt_inc   = to_cnt_q + TO_W'(1);

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        open_bus_d = open_bus_q;
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;
        ram_addr_d = ram_addr_q;
        ppu_addr_d = ppu_addr_q;
        io_addr_d  = io_addr_q;
        prg_addr_d = prg_addr_q;
        finish_d   = 1'b0;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        prg_en_d   = 1'b0;
        prg_we_d   = 1'b0;
        ppu_cmd_d  = 1'b0;
        io_cmd_d   = 1'b0;
`ifdef PRG_RAM_EN
        wram_addr_d = wram_addr_q;
        wram_en_d   = 1'b0;
        wram_we_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (I_Cmd) begin
                    region_d   = w_region;
                    rw_d       = I_RW;
                    wdata_d    = I_WData;
                    ram_addr_d = I_Addr[10:0];
                    ppu_addr_d = I_Addr[2:0];
                    io_addr_d  = I_Addr[4:0];
                    prg_addr_d = I_Addr[14:0];
                    to_cnt_d   = '0;
`ifdef PRG_RAM_EN
                    wram_addr_d = I_Addr[12:0];
`endif
                    case (w_region)
                        c_RGN_RAM: begin
                            ram_en_d = 1'b1;
                            ram_we_d = !I_RW;
                            state_d  = S_MEM;
                        end
                        c_RGN_PRG: begin
                            prg_en_d = 1'b1;
                            prg_we_d = !I_RW;
                            state_d  = S_MEM;
                        end
`ifdef PRG_RAM_EN
                        c_RGN_WRAM: begin
                            wram_en_d = 1'b1;
                            wram_we_d = !I_RW;
                            state_d   = S_MEM;
                        end
`endif
                        c_RGN_PPU: begin
                            ppu_cmd_d = 1'b1;
                            state_d   = S_HS;
                        end
                        c_RGN_IO: begin
                            io_cmd_d = 1'b1;
                            state_d  = S_HS;
                        end
                        default: begin
                            // Unmapped: a read returns whatever was last on the bus.
                            data_d  = open_bus_q;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MEM: begin
                state_d = S_MEMDATA;
            end
            S_MEMDATA: begin
                // Memory read data appears one cycle after the strobe.
                if (rw_q) begin
                    data_d = w_mem_rdata;
                end
                state_d = S_DONE;
            end
            S_HS: begin
                to_cnt_d = w_cnt_inc;
                // A finish that arrives on the timeout cycle still wins.
                if (w_hs_finish) begin
                    if (rw_q) begin
                        data_d = w_hs_rdata;
                    end
                    state_d = S_DONE;
                end else if (w_cnt_inc == c_TO_LIMIT) begin
                    err_d   = 1'b1;
                    data_d  = open_bus_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                finish_d = 1'b1;
                if (rw_q) begin
                    rdata_d    = data_q;
                    open_bus_d = data_q;
                end else begin
                    open_bus_d = wdata_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            region_q   <= c_RGN_NONE;
            rw_q       <= 1'b0;
            wdata_q    <= 8'h00;
            data_q     <= 8'h00;
            rdata_q    <= 8'h00;
            open_bus_q <= 8'h00;
            finish_q   <= 1'b0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
            ram_addr_q <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ppu_addr_q <= '0;
            ppu_cmd_q  <= 1'b0;
            io_addr_q  <= '0;
            io_cmd_q   <= 1'b0;
            prg_addr_q <= '0;
            prg_en_q   <= 1'b0;
            prg_we_q   <= 1'b0;
`ifdef PRG_RAM_EN
            wram_addr_q <= '0;
            wram_en_q   <= 1'b0;
            wram_we_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            open_bus_q <= open_bus_d;
            finish_q   <= finish_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ppu_addr_q <= ppu_addr_d;
            ppu_cmd_q  <= ppu_cmd_d;
            io_addr_q  <= io_addr_d;
            io_cmd_q   <= io_cmd_d;
            prg_addr_q <= prg_addr_d;
            prg_en_q   <= prg_en_d;
            prg_we_q   <= prg_we_d;
`ifdef PRG_RAM_EN
            wram_addr_q <= wram_addr_d;
            wram_en_q   <= wram_en_d;
            wram_we_q   <= wram_we_d;
`endif
        end
    end

    assign I_RData     = rdata_q;
    assign I_Finish    = finish_q;
    assign err_timeout = err_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ppu_addr    = ppu_addr_q;
    assign ppu_wdata   = wdata_q;
    assign ppu_rw      = rw_q;
    assign ppu_cmd     = ppu_cmd_q;
    assign io_addr     = io_addr_q;
    assign io_wdata    = wdata_q;
    assign io_rw       = rw_q;
    assign io_cmd      = io_cmd_q;
    assign prg_addr    = prg_addr_q;
    assign prg_wdata   = wdata_q;
    assign prg_en      = prg_en_q;
    assign prg_we      = prg_we_q;
`ifdef PRG_RAM_EN
    assign wram_addr   = wram_addr_q;
    assign wram_wdata  = wdata_q;
    assign wram_en     = wram_en_q;
    assign wram_we     = wram_we_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_decoder
// Description : Scoreboard bench for cpu_bus_decoder. Target models (RAM,
//               PRG, PPU, IO) sit around the DUT. A reference model predicts
//               each transaction from the address map and pushes the
//               prediction into a queue. A monitor pops and compares the
//               prediction on every I_Finish.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_decoder;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int K_RAM = 0, K_PPU = 1, K_IO = 2, K_PRG = 3, K_NONE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] I_Addr = '0;
    logic [7:0]  I_WData = '0;
    logic        I_RW = 1'b0;
    logic        I_Cmd = 1'b0;
    logic [7:0]  I_RData;
    logic        I_Finish;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_en, ram_we;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_wdata, ppu_rdata;
    logic        ppu_rw, ppu_cmd, ppu_finish;
    logic [4:0]  io_addr;
    logic [7:0]  io_wdata, io_rdata;
    logic        io_rw, io_cmd, io_finish;
    logic [14:0] prg_addr;
    logic [7:0]  prg_wdata, prg_rdata;
    logic        prg_en, prg_we;
    logic        err_timeout;

    cpu_bus_decoder #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(7)) u_dut (
        .clk(clk), .rst(rst),
        .I_Addr(I_Addr), .I_WData(I_WData), .I_RW(I_RW), .I_Cmd(I_Cmd),
        .I_RData(I_RData), .I_Finish(I_Finish),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en),
        .ram_we(ram_we), .ram_rdata(ram_rdata),
        .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata), .ppu_rw(ppu_rw),
        .ppu_cmd(ppu_cmd), .ppu_rdata(ppu_rdata), .ppu_finish(ppu_finish),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rw(io_rw),
        .io_cmd(io_cmd), .io_rdata(io_rdata), .io_finish(io_finish),
        .prg_addr(prg_addr), .prg_wdata(prg_wdata), .prg_en(prg_en),
        .prg_we(prg_we), .prg_rdata(prg_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] prg_init(input int i);
        if (i == 32'h7FFC) return 8'h00;
        return 8'((i * 7 + (i >> 7)) ^ 32'hA5);
    endfunction

    // ---------------- target models ----------------
    logic [7:0] ram_mem [0:2047];
    logic [7:0] prg_mem [0:32767];
    logic       mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 2048; i++) ram_mem[i] <= 8'h00;
            for (int i = 0; i < 32768; i++) prg_mem[i] <= prg_init(i);
            mem_init_done <= 1'b1;
        end else begin
            if (ram_en) begin
                if (ram_we) ram_mem[ram_addr] <= ram_wdata;
                else        ram_rdata <= ram_mem[ram_addr];
            end
            if (prg_en) begin
                if (prg_we) prg_mem[prg_addr] <= prg_wdata;
                else        prg_rdata <= prg_mem[prg_addr];
            end
        end
    end

    // Handshake targets: finish is sampled by the DUT hs_wait cycles after it
    // samples cmd; hs_wait == 0 means the target never answers.
    int         hs_wait = 0;
    logic [7:0] hs_resp = 8'h00;

    initial begin
        int w;
        ppu_finish = 1'b0;
        ppu_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            w = hs_wait;
            if (ppu_cmd === 1'b1 && w > 0) begin
                repeat (w) @(posedge clk);
                #1 ppu_finish = 1'b1;
                ppu_rdata = hs_resp;
                @(posedge clk);
                #1 ppu_finish = 1'b0;
            end
        end
    end

    initial begin
        int w;
        io_finish = 1'b0;
        io_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            w = hs_wait;
            if (io_cmd === 1'b1 && w > 0) begin
                repeat (w) @(posedge clk);
                #1 io_finish = 1'b1;
                io_rdata = hs_resp;
                @(posedge clk);
                #1 io_finish = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] rdata;
        int         lat;
        logic       err;
        int         kind;
        int         taddr;
        logic       rw;
        int         issue;
    } exp_t;

    exp_t exp_q[$];

    int n_ram = 0, n_ppu = 0, n_io = 0, n_prg = 0;

    initial begin
        exp_t e;
        int   strobes_exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_ram = 0; n_ppu = 0; n_io = 0; n_prg = 0;
            end else begin
                if (ram_en === 1'b1) begin
                    n_ram++;
                    if (exp_q.size() > 0) begin
                        chk("ram_addr", 32'(ram_addr), exp_q[0].taddr);
                        chk("ram_we", 32'(ram_we), 32'(!exp_q[0].rw));
                    end
                end
                if (prg_en === 1'b1) begin
                    n_prg++;
                    if (exp_q.size() > 0) begin
                        chk("prg_addr", 32'(prg_addr), exp_q[0].taddr);
                        chk("prg_we", 32'(prg_we), 32'(!exp_q[0].rw));
                    end
                end
                if (ppu_cmd === 1'b1) begin
                    n_ppu++;
                    if (exp_q.size() > 0) begin
                        chk("ppu_addr", 32'(ppu_addr), exp_q[0].taddr);
                        chk("ppu_rw", 32'(ppu_rw), 32'(exp_q[0].rw));
                    end
                end
                if (io_cmd === 1'b1) begin
                    n_io++;
                    if (exp_q.size() > 0) begin
                        chk("io_addr", 32'(io_addr), exp_q[0].taddr);
                        chk("io_rw", 32'(io_rw), 32'(exp_q[0].rw));
                    end
                end
                if (I_Finish === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_finish: got I_Finish=1, expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        strobes_exp = (e.kind == K_RAM) ? 1000 : (e.kind == K_PPU) ? 100 :
                                      (e.kind == K_IO)  ? 10   : (e.kind == K_PRG) ? 1 : 0;
                        chk("rdata", 32'(I_RData), 32'(e.rdata));
                        chk("latency", cyc - e.issue, e.lat);
                        chk("err_timeout", 32'(err_timeout), 32'(e.err));
                        chk("strobes", n_ram * 1000 + n_ppu * 100 + n_io * 10 + n_prg, strobes_exp);
                    end
                    n_ram = 0; n_ppu = 0; n_io = 0; n_prg = 0;
                end
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    logic [7:0] ram_ref [0:2047];
    logic [7:0] prg_ref [0:32767];
    logic [7:0] ob_ref   = 8'h00;
    logic [7:0] last_ref = 8'h00;
    logic       err_ref  = 1'b0;

    task automatic do_txn(input logic [15:0] a, input logic [7:0] wd, input logic rw,
                          input int w, input logic [7:0] resp);
        exp_t       e;
        logic [7:0] d;
        logic       ok;
        d = ob_ref;
        if (a < 16'h2000) begin
            e.kind = K_RAM; e.taddr = int'(a % 2048); e.lat = 4;
            if (rw) d = ram_ref[a % 2048];
            else    ram_ref[a % 2048] = wd;
        end else if (a < 16'h4000) begin
            e.kind = K_PPU; e.taddr = int'(a % 8);
        end else if (a < 16'h4020) begin
            e.kind = K_IO; e.taddr = int'(a - 16'h4000);
        end else if (a >= 16'h8000) begin
            e.kind = K_PRG; e.taddr = int'(a - 16'h8000); e.lat = 4;
            if (rw) d = prg_ref[a - 16'h8000];
            else    prg_ref[a - 16'h8000] = wd;
        end else begin
            e.kind = K_NONE; e.taddr = 0; e.lat = 2;
        end
        if (e.kind == K_PPU || e.kind == K_IO) begin
            ok = (w >= 1) && (w <= TIMEOUT_CYCLES - 1);
            e.lat = ok ? 3 + w : TIMEOUT_CYCLES + 2;
            if (ok) d = resp;
            else    err_ref = 1'b1;
        end
        if (rw) begin
            last_ref = d;
            ob_ref   = d;
        end else begin
            ob_ref   = wd;
        end
        e.rdata = last_ref;
        e.err   = err_ref;
        e.rw    = rw;
        hs_wait = w;
        hs_resp = resp;
        @(posedge clk);
        #1;
        I_Addr = a; I_WData = wd; I_RW = rw; I_Cmd = 1'b1;
        e.issue = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1 I_Cmd = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL finish_timeout: got no I_Finish for addr 0x%04h, expected one", a);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  wd;
        logic        rw;
        int          w, cat, r;
        for (int i = 0; i < 2048; i++) ram_ref[i] = 8'h00;
        for (int i = 0; i < 32768; i++) prg_ref[i] = prg_init(i);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_finish", 32'(I_Finish), 0);
        chk("reset_rdata", 32'(I_RData), 0);
        chk("reset_err", 32'(err_timeout), 0);
        chk("reset_strobes", 32'({ram_en, ram_we, prg_en, prg_we, ppu_cmd, io_cmd}), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // RAM through a mirror
        do_txn(16'h0801, 8'h5A, 1'b0, 0, 8'h00);
        do_txn(16'h0001, 8'h00, 1'b1, 0, 8'h00);
        // PPU handshake
        do_txn(16'h3FFA, 8'h00, 1'b1, 5, 8'hC3);
        // IO timeout after a read of 0x77
        do_txn(16'h2002, 8'h00, 1'b1, 2, 8'h77);
        do_txn(16'h4016, 8'h00, 1'b1, 0, 8'h00);
        // Open bus after an IO write
        do_txn(16'h4000, 8'h9C, 1'b0, 3, 8'h00);
        do_txn(16'h5000, 8'h00, 1'b1, 0, 8'h00);
        // PRG path
        do_txn(16'hFFFC, 8'h00, 1'b1, 0, 8'h00);
        do_txn(16'h8000, 8'h01, 1'b0, 0, 8'h00);
        // Handshake boundary: last-cycle finish wins, one later times out
        do_txn(16'h2007, 8'h00, 1'b1, TIMEOUT_CYCLES - 1, 8'h3E);
        do_txn(16'h4015, 8'h00, 1'b1, TIMEOUT_CYCLES, 8'h44);
        do_txn(16'h6123, 8'h00, 1'b1, 0, 8'h00);

        // Reset while waiting in the handshake state
        hs_wait = 0;
        @(posedge clk);
        #1 I_Addr = 16'h4016; I_RW = 1'b1; I_Cmd = 1'b1;
        @(posedge clk);
        #1 I_Cmd = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        ob_ref = 8'h00; last_ref = 8'h00; err_ref = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_strobes", 32'({ram_en, ram_we, prg_en, prg_we, ppu_cmd, io_cmd, I_Finish}), 0);
        chk("midrst_err", 32'(err_timeout), 0);
        chk("midrst_rdata", 32'(I_RData), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        do_txn(16'h1801, 8'h00, 1'b1, 0, 8'h00);
        do_txn(16'h4017, 8'h00, 1'b1, 4, 8'hB2);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            cat = $urandom_range(0, 9);
            case (cat)
                0, 1, 2: a = 16'($urandom_range(0, 16'h1FFF));
                3:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
                4:       a = 16'($urandom_range(16'h4000, 16'h401F));
                5, 6, 7: a = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: a = 16'($urandom_range(16'h4020, 16'h7FFF));
            endcase
            wd = 8'($urandom);
            rw = 1'($urandom);
            r  = $urandom_range(0, 9);
            if (r == 0)      w = 0;
            else if (r == 1) w = $urandom_range(TIMEOUT_CYCLES - 4, TIMEOUT_CYCLES);
            else             w = $urandom_range(1, 8);
            do_txn(a, wd, rw, w, 8'($urandom));
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
